// File: rtl/instruction_fetch_queue.sv
// Instruction fetch queue: issues sequential PC fetches to a 1-cycle-latency
// instruction ROM and buffers the returned words (with their PCs) in a small
// FIFO for decode. A redirect from execute flushes everything and restarts
// fetch at the new target.
//
// Optional feature macro: FETCH_MISALIGN_TRAP_EN
//   defined   -> a redirect to a non-word-aligned target raises the sticky
//                'misaligned' output and halts fetch until reset.
//   undefined -> no 'misaligned' port; the low two target bits are dropped.
module instruction_fetch_queue #(
  parameter logic [31:0] RESET_PC    = 32'h00000000,
  parameter int          QUEUE_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic        misaligned
`endif
);

  localparam int PW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CW = $clog2(QUEUE_DEPTH + 1);
  localparam logic [PW-1:0] LAST_SLOT   = PW'(QUEUE_DEPTH - 1);
  localparam logic [CW:0]   DEPTH_LIMIT = (CW + 1)'(QUEUE_DEPTH);
  localparam logic [31:0]   NOP         = 32'h00000013;

  logic [31:0]   pc;
  logic          inflight;
  logic [31:0]   inflight_tag;
  logic [31:0]   q_instr [QUEUE_DEPTH];
  logic [31:0]   q_pc    [QUEUE_DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;
  logic [CW:0]   occupancy;
  logic          halted;
  logic          issue;
  logic          push;
  logic          pop;
  logic [31:0]   redirect_target;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic misaligned_q;
  logic misaligned_hit;

  assign misaligned      = misaligned_q;
  assign halted          = misaligned_q;
  assign redirect_target = redirect_pc;
  assign misaligned_hit  = redirect_valid && (redirect_pc[1:0] != 2'b00);
`else
  assign halted          = 1'b0;
  assign redirect_target = redirect_pc & 32'hFFFF_FFFC;
`endif

  // Wrap a queue slot index back to zero after the last entry.
  function automatic logic [PW-1:0] next_slot(input logic [PW-1:0] slot);
    return (slot == LAST_SLOT) ? '0 : slot + PW'(1);
  endfunction

  assign rom_addr  = pc;
  assign out_valid = (count != '0);
  assign out_instr = out_valid ? q_instr[head] : NOP;
  assign out_pc    = out_valid ? q_pc[head] : 32'h0;

  // Handshake decisions; reset and redirect both suppress every queue action.
  always_comb begin
    occupancy = {1'b0, count} + {{CW{1'b0}}, inflight};
    issue     = !rst && !redirect_valid && !halted && (occupancy < DEPTH_LIMIT);
    push      = !rst && !redirect_valid && inflight;
    pop       = !rst && !redirect_valid && out_valid && out_ready;
  end

  // Queue storage needs no reset: occupancy is tracked by count.
  always_ff @(posedge clk) begin
    if (push) begin
      q_instr[tail] <= rom_data;
      q_pc[tail]    <= inflight_tag;
    end
  end

  // PC, inflight tracking and queue pointers; redirect flushes like reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc           <= RESET_PC;
      inflight     <= 1'b0;
      inflight_tag <= 32'h0;
      head         <= '0;
      tail         <= '0;
      count        <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
      misaligned_q <= 1'b0;
`endif
    end else if (redirect_valid) begin
      pc       <= redirect_target;
      inflight <= 1'b0;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
      if (misaligned_hit) begin
        misaligned_q <= 1'b1;
      end
`endif
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_tag <= pc;
        pc           <= pc + 32'd4;
      end
      if (push) begin
        tail <= next_slot(tail);
      end
      if (pop) begin
        head <= next_slot(head);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
